// File: rtl/e_mdu_pkg.sv
// Shared MD-unit op codes, rd_sel encodings and op-class decode for e_mdu.
// MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU legal multiply-class ops; otherwise they decode as unused.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_t;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_MULT = 3'd1,
    CLS_DIV  = 3'd2,
    CLS_MTHI = 3'd3,
    CLS_MTLO = 3'd4
  } cls_t;

  function automatic cls_t op_class(input mdu_op_t op);
    cls_t c;
    c = CLS_NONE;
    case (op)
      OP_MULT, OP_MULTU: c = CLS_MULT;
      OP_DIV, OP_DIVU:   c = CLS_DIV;
      OP_MTHI:           c = CLS_MTHI;
      OP_MTLO:           c = CLS_MTLO;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: c = CLS_MULT;
`endif
      default:           c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational {hi,lo} result for an MD op; zero latency, no flow control.
// Divide by zero returns the incoming {hi,lo} so the later commit is a no-op. MDU_MADD_EN adds accumulate ops.
module e_mdu_calc
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_t              op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     hi,
  input  logic [WIDTH-1:0]     lo,
  output logic [2*WIDTH-1:0]   res
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [W2-1:0] acc;
  logic [W2-1:0] prod_s;
  logic [W2-1:0] prod_u;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic [WIDTH-1:0] q_s, r_s, q_u, r_u;
  logic b_zero;
  logic ovf;

  always_comb begin
    acc    = {hi, lo};
    sa     = a;
    sb     = b;
    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    q_s    = sa / sb;
    r_s    = sa % sb;
    q_u    = a / b;
    r_u    = a % b;
    b_zero = (b == '0);
    ovf    = (a == MOST_NEG) && (b == '1);
    res    = acc;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        if (!b_zero) res = ovf ? {{WIDTH{1'b0}}, MOST_NEG} : {r_s, q_s};
      end
      OP_DIVU: begin
        if (!b_zero) res = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
`endif
      default:  res = acc;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: result commits to HI/LO MULT_CYCLES/DIV_CYCLES edges after start.
// No queueing: starts during busy are dropped, so the hazard unit stalls on busy|start. Macro MDU_MADD_EN enables MADD/MSUB.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_sel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_op_t             op_e;
  cls_t                cls;
  state_t              state;
  logic [2*WIDTH-1:0]  calc_res;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;

  assign op_e = mdu_op_t'(op);
  assign cls  = op_class(op_e);

  e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op  (op_e),
    .a   (a),
    .b   (b),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state    = (cnt_q != '0) ? RUN : IDLE;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state)
      IDLE: begin
        if (start) begin
          case (cls)
            CLS_MULT: begin
              shadow_d = calc_res;
              cnt_d    = CW'(MULT_CYCLES);
            end
            CLS_DIV: begin
              shadow_d = calc_res;
              cnt_d    = CW'(DIV_CYCLES);
            end
            CLS_MTHI: hi_d = a;
            CLS_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        // Last busy cycle: the shadow result becomes architectural.
        if (cnt_q == CW'(1)) {hi_d, lo_d} = shadow_q;
      end
      default: ;
    endcase
  end

  assign busy    = (cnt_q != '0);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (rd_sel == RD_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu with default latencies; MDU_MADD_EN selects the accumulate expectations.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
    total_cnt++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    do_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
    total_cnt++; if (busy !== 1'b1) $display("FAIL mult_busy_rise: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL mult_hold: got %h_%h want 0_0", hi, lo); else pass_cnt++;
    wait_busy(n);
    total_cnt++; if (n !== 5) $display("FAIL mult_busy_len: got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFEB) $display("FAIL mult_lo: got %h want ffffffeb", lo); else pass_cnt++;
    rd_sel = 1'b1; #1;
    total_cnt++; if (rd_data !== 32'hFFFFFFFF) $display("FAIL mult_rd_hi: got %h want ffffffff", rd_data); else pass_cnt++;
    rd_sel = 1'b0; #1;
    total_cnt++; if (rd_data !== 32'hFFFFFFEB) $display("FAIL mult_rd_lo: got %h want ffffffeb", rd_data); else pass_cnt++;
  endtask

  task automatic test_div();
    int n;
    do_op(OP_DIVU, 32'd100, 32'd7);
    wait_busy(n);
    total_cnt++; if (n !== 10) $display("FAIL divu_busy_len: got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (lo !== 32'd14) $display("FAIL divu_lo: got %h want 0000000e", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd2) $display("FAIL divu_hi: got %h want 00000002", hi); else pass_cnt++;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_busy(n);
    total_cnt++; if (n !== 10) $display("FAIL div_busy_len: got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", hi); else pass_cnt++;
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(n);
    total_cnt++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL div_ovf_hi: got %h want 00000000", hi); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int n;
    do_op(OP_MTHI, 32'h1234, 32'h0);
    do_op(OP_MTLO, 32'h1234, 32'h0);
    total_cnt++; if (busy !== 1'b0) $display("FAIL mt_busy: got %b want 0", busy); else pass_cnt++;
    do_op(OP_DIV, 32'd5, 32'd0);
    wait_busy(n);
    total_cnt++; if (n !== 10) $display("FAIL divz_busy_len: got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (hi !== 32'h1234) $display("FAIL divz_hi: got %h want 00001234", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h1234) $display("FAIL divz_lo: got %h want 00001234", lo); else pass_cnt++;
  endtask

  task automatic test_mt_during_run();
    int n;
    do_op(OP_MTHI, 32'hDEAD, 32'h0);
    total_cnt++; if (hi !== 32'hDEAD) $display("FAIL mthi_hi: got %h want 0000dead", hi); else pass_cnt++;
    do_op(OP_MULT, 32'd6, 32'd7);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op = (i == 1) ? OP_DIVU : OP_MTLO; a = 32'h5555; b = 32'd3;
      tick();
    end
    start = 1'b0; op = OP_NONE;
    total_cnt++; if (hi !== 32'hDEAD) $display("FAIL run_hold_hi: got %h want 0000dead", hi); else pass_cnt++;
    wait_busy(n);
    total_cnt++; if (n + 3 !== 5) $display("FAIL run_busy_len: got %0d want 5", n + 3); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL run_commit_hi: got %h want 00000000", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd42) $display("FAIL run_commit_lo: got %h want 0000002a", lo); else pass_cnt++;
    do_op(OP_NONE, 32'h9999, 32'h1);
    do_op(4'd15, 32'h9999, 32'h1);
    total_cnt++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd42)
      $display("FAIL unused_op: got busy=%b %h_%h want busy=0 00000000_0000002a", busy, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_op(OP_MTHI, 32'h77, 32'h0);
    do_op(OP_DIVU, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL midrst_hilo: got %h_%h want 0_0", hi, lo); else pass_cnt++;
    reset = 1'b0;
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total_cnt++; if (busy !== 1'b1) $display("FAIL postrst_accept: got %b want 1", busy); else pass_cnt++;
    wait_busy(n);
    total_cnt++; if (n !== 5) $display("FAIL multu_busy_len: got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h1) $display("FAIL multu_lo: got %h want 00000001", lo); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    do_op(OP_MULTU, 32'd3, 32'd4);
    wait_busy(n);
    total_cnt++; if (lo !== 32'd12) $display("FAIL b2b_mult_lo: got %h want 0000000c", lo); else pass_cnt++;
    do_op(OP_DIVU, 32'd9, 32'd2);
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", busy); else pass_cnt++;
    wait_busy(n);
    total_cnt++; if (lo !== 32'd4 || hi !== 32'd1) $display("FAIL b2b_div: got %h_%h want 00000001_00000004", hi, lo); else pass_cnt++;
  endtask

  task automatic test_madd();
    int n;
    do_op(OP_MTHI, 32'h0, 32'h0);
    do_op(OP_MTLO, 32'd10, 32'h0);
`ifdef MDU_MADD_EN
    do_op(OP_MADD, 32'd2, 32'd3);
    wait_busy(n);
    total_cnt++; if (n !== 5) $display("FAIL madd_busy_len: got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0 || lo !== 32'd16) $display("FAIL madd: got %h_%h want 00000000_00000010", hi, lo); else pass_cnt++;
    do_op(OP_MSUBU, 32'd5, 32'd5);
    wait_busy(n);
    total_cnt++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF7) $display("FAIL msubu: got %h_%h want ffffffff_fffffff7", hi, lo); else pass_cnt++;
`else
    do_op(OP_MADD, 32'd2, 32'd3);
    total_cnt++; if (busy !== 1'b0) $display("FAIL madd_off_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0 || lo !== 32'd10) $display("FAIL madd_off: got %h_%h want 00000000_0000000a", hi, lo); else pass_cnt++;
    do_op(OP_MSUBU, 32'd5, 32'd5);
    total_cnt++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd10)
      $display("FAIL msubu_off: got busy=%b %h_%h want busy=0 00000000_0000000a", busy, hi, lo);
    else pass_cnt++;
    n = 0;
`endif
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = OP_NONE; a = '0; b = '0; rd_sel = RD_LO;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mt_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_madd();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
